// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit of the 5-stage RISC-V pipeline.
// Takes the EX/MEM fields, issues word-aligned dmem requests with byte
// enables over a req/ack handshake, stalls upstream while a request is
// outstanding, aligns/extends load data and registers the MEM/WB fields.
// Optional feature: define DMEM_TIMEOUT_EN to abandon a request that has
// not been acknowledged within TIMEOUT_CYCLES cycles.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memreadM_i,
    input  logic        memwriteM_i,
    input  logic        regwriteM_i,
    input  logic [2:0]  funct3M_i,
    input  logic [31:0] aluresultM_i,
    input  logic [31:0] writedataM_i,
    input  logic [4:0]  rdM_i,
    input  logic [31:0] pcplus4M_i,
    output logic        stallM_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] readdataW_o,
    output logic [31:0] aluresultW_o,
    output logic [4:0]  rdW_o,
    output logic [31:0] pcplus4W_o,
    output logic        regwriteW_o,
    output logic        err_o
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [31:0] pc4_q;
    logic [31:0] alu_q;
    logic        rw_q;

    logic        mem_op;
    logic        legal_f3;
    logic        misaligned;
    logic        bad;
    logic        go;
    logic        timeout_hit;
    logic [1:0]  off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_ext;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CW-1:0] cnt;
`endif

    // Decode the incoming access: legality, alignment, lanes and stall
    always_comb begin
        off        = aluresultM_i[1:0];
        mem_op     = memreadM_i | memwriteM_i;
        legal_f3   = 1'b0;
        if (memwriteM_i) begin
            case (funct3M_i)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end else begin
            case (funct3M_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                default:                                legal_f3 = 1'b0;
            endcase
        end
        misaligned = ((funct3M_i[1:0] == 2'b01) && off[0]) ||
                     ((funct3M_i[1:0] == 2'b10) && (off != 2'b00));
        bad        = mem_op && (!legal_f3 || misaligned);
        go         = (state == IDLE) && mem_op && !bad;
        case (funct3M_i[1:0])
            2'b00:   be_next = 4'b0001 << off;
            2'b01:   be_next = 4'b0011 << off;
            default: be_next = 4'b1111;
        endcase
        wdata_next = writedataM_i << {off, 3'b000};
`ifdef DMEM_TIMEOUT_EN
        timeout_hit = (state == REQ) && !dmem_ack_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
        timeout_hit = 1'b0;
`endif
        if (state == IDLE) stallM_o = go;
        else               stallM_o = !dmem_ack_i && !timeout_hit;
    end

    // Align the returned word to its byte lane and extend per funct3
    always_comb begin
        shifted = dmem_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Request FSM with registered dmem and MEM/WB outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            pc4_q        <= '0;
            alu_q        <= '0;
            rw_q         <= 1'b0;
            readdataW_o  <= '0;
            aluresultW_o <= '0;
            rdW_o        <= '0;
            pcplus4W_o   <= '0;
            regwriteW_o  <= 1'b0;
            err_o        <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state        <= REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= memwriteM_i;
                        dmem_addr_o  <= {aluresultM_i[31:2], 2'b00};
                        dmem_be_o    <= be_next;
                        dmem_wdata_o <= wdata_next;
                        f3_q         <= funct3M_i;
                        off_q        <= off;
                        rd_q         <= rdM_i;
                        pc4_q        <= pcplus4M_i;
                        alu_q        <= aluresultM_i;
                        rw_q         <= regwriteM_i;
`ifdef DMEM_TIMEOUT_EN
                        cnt          <= '0;
`endif
                        readdataW_o  <= '0;
                        aluresultW_o <= '0;
                        rdW_o        <= '0;
                        pcplus4W_o   <= '0;
                        regwriteW_o  <= 1'b0;
                    end else if (bad) begin
                        err_o        <= 1'b1;
                        readdataW_o  <= '0;
                        aluresultW_o <= '0;
                        rdW_o        <= '0;
                        pcplus4W_o   <= '0;
                        regwriteW_o  <= 1'b0;
                    end else begin
                        readdataW_o  <= '0;
                        aluresultW_o <= aluresultM_i;
                        rdW_o        <= rdM_i;
                        pcplus4W_o   <= pcplus4M_i;
                        regwriteW_o  <= regwriteM_i;
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        state        <= IDLE;
                        dmem_req_o   <= 1'b0;
                        readdataW_o  <= dmem_we_o ? '0 : load_ext;
                        aluresultW_o <= alu_q;
                        rdW_o        <= rd_q;
                        pcplus4W_o   <= pc4_q;
                        regwriteW_o  <= rw_q;
                    end else begin
                        readdataW_o  <= '0;
                        aluresultW_o <= '0;
                        rdW_o        <= '0;
                        pcplus4W_o   <= '0;
                        regwriteW_o  <= 1'b0;
                        if (timeout_hit) begin
                            state      <= IDLE;
                            dmem_req_o <= 1'b0;
                            err_o      <= 1'b1;
                        end
`ifdef DMEM_TIMEOUT_EN
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the 5-stage RISC-V pipeline.
- Consumes the fields held in the EX/MEM stage register: address from the ALU result, store data, rd, pc+4 and the memory control bits.
- Issues word-aligned requests with byte enables to data memory over a req/ack handshake, and stalls upstream while a request is outstanding.
- Aligns and sign/zero-extends load data, then registers the results into the MEM/WB fields.

Parameters:
- TIMEOUT_CYCLES, 64, ack wait limit in cycles; used only when DMEM_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- memreadM_i  in  1  load in MEM stage
- memwriteM_i  in  1  store in MEM stage
- regwriteM_i  in  1  register write enable in MEM stage
- funct3M_i  in  3  access size/sign (instr[14:12])
- aluresultM_i  in  32  byte address or ALU result
- writedataM_i  in  32  store data (rs2)
- rdM_i  in  5  destination register
- pcplus4M_i  in  32  pc+4
- stallM_o  out  1  hold IF/ID/EX and EX/MEM registers
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, [1:0] = 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_ack_i  in  1  request accepted/completed, single-cycle pulse
- dmem_rdata_i  in  32  read word, valid when ack = 1
- readdataW_o  out  32  extended load data
- aluresultW_o  out  32  registered ALU result
- rdW_o  out  5  registered rd
- pcplus4W_o  out  32  registered pc+4
- regwriteW_o  out  1  registered write enable
- err_o  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
  - Assertion mid-request drops dmem_req_o immediately.
  - The transaction is abandoned.
- FSM has two states, IDLE and REQ.
- IDLE, no memory op (memread = memwrite = 0):
  - stallM_o = 0.
  - W registers load aluresult, rd, pc+4 and regwrite on the next edge; readdataW_o = 0.
  - Latency is 1 cycle.
- IDLE, memory op:
  - memwrite has priority if both are set.
  - Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Misaligned: H with addr[0] = 1, or W with addr[1:0] ≠ 0.
- Illegal funct3 or misaligned access:
  - No request is issued.
  - err_o pulses on the next edge.
  - W gets a bubble (regwriteW_o = 0, rdW_o = 0).
  - stallM_o = 0.
- Legal access, same cycle:
  - stallM_o = 1 combinationally.
  - Latch addr = {aluresult[31:2], 2'b00} and we.
  - Byte enables: B = 0001 << a[1:0]; H = 0011 << a[1:0]; W = 1111.
  - Store data shifted left by 8 × a[1:0] from its low bytes.
  - Latch funct3, a[1:0], rd, pc+4, regwrite.
  - Next state REQ; W gets a bubble.
- REQ:
  - dmem_req_o = 1; addr, we, be and wdata held stable until ack.
  - stallM_o = ~dmem_ack_i.
  - Each cycle without ack: W gets a bubble.
  - On ack: W registers load the latched fields. For loads, readdataW_o = (rdata >> 8 × a[1:0]), sign- or zero-extended per funct3; for stores, readdataW_o = 0. Next state IDLE.
- Minimum memory-op latency is 2 cycles (ack in the first REQ cycle).
- The next instruction is presented on the cycle after ack, since stall is low in the ack cycle.
- dmem_ack_i in IDLE is ignored.
- dmem_req_o is a registered output; it never depends combinationally on dmem_ack_i.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES − 1 without ack: the FSM drops the request, pulses err_o, writes a bubble to W, returns to IDLE, and deasserts stall that cycle.
- Undefined: REQ waits indefinitely; no counter logic is present.

Test Plan:
- ALU op, aluresult = 0x1234, rd = 5, regwrite = 1 → next cycle aluresultW_o = 0x1234, rdW_o = 5, regwriteW_o = 1; stallM_o never asserts.
- SB addr = 0x1003, wdata = 0x000000AB, ack after 2 REQ cycles → dmem_addr_o = 0x1000, be = 1000, wdata = 0xAB000000, we = 1; stall is high for 3 cycles; no spurious W write.
- LH addr = 0x2002, rdata = 0x8001_0000, ack in first REQ cycle → readdataW_o = 0xFFFF8001; LHU at the same address → 0x00008001; stall is high for exactly 1 cycle.
- LW addr = 0x2001 → no dmem_req_o, err_o pulses 1 cycle, regwriteW_o = 0, stall stays 0.
- rst_i asserted during REQ → dmem_req_o and stallM_o go to 0 without waiting for a clock edge. After release, an ALU op completes normally.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, LW with no ack → req is high for 4 cycles, then err_o pulses, regwriteW_o = 0, and the FSM returns to IDLE.
